// File: rtl/regbus_pkg.sv
// Shared opcode/status codes and bridge FSM state encoding for the host-link
// to register-bus bridge.
package regbus_pkg;

    localparam logic [7:0] OP_READ    = 8'h01;
    localparam logic [7:0] OP_WRITE   = 8'h02;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_REGERR  = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_BADOP   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        ADDRH,
        ADDRL,
        WDATA,
        REQ,
        WAIT,
        RESP
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_READ) || (b == OP_WRITE);
    endfunction

endpackage

// File: rtl/regbus_bridge.sv
// Byte-stream command bridge: parses read/write frames from the host link,
// issues one register-bus transaction and streams back a status/data response.
module regbus_bridge
    import regbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxdata,
    input  logic        rxvalid,
    output logic        rxready,
    output logic [7:0]  txdata,
    output logic        txvalid,
    input  logic        txready,
    output logic        regreq,
    output logic        regwr,
    output logic [11:0] regaddr,
    output logic [31:0] regwdata,
    input  logic        regack,
    input  logic        regerr,
    input  logic [31:0] regrdata
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic        regwr_q;
    logic [11:0] regaddr_q;
    logic [31:0] regwdata_q;
    logic [15:0] timer_q;
    logic [2:0]  cnt_q;
    logic [7:0]  txdata_q;
    logic [31:0] shift_q;

    logic rx_fire;
    logic tx_fire;

    // rxready is gated by rst so no byte is taken while reset is held.
    assign rxready  = !rst && (state_q inside {IDLE, ADDRH, ADDRL, WDATA});
    assign rx_fire  = rxvalid && rxready;
    assign txvalid  = (state_q == RESP);
    assign tx_fire  = txvalid && txready;
    assign txdata   = txdata_q;
    assign regreq   = (state_q == REQ);
    assign regwr    = regwr_q;
    assign regaddr  = regaddr_q;
    assign regwdata = regwdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            regwr_q    <= 1'b0;
            regaddr_q  <= '0;
            regwdata_q <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            txdata_q   <= '0;
            shift_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_fire) begin
                        if (is_opcode(rxdata)) begin
                            regwr_q <= (rxdata == OP_WRITE);
                            state_q <= ADDRH;
                        end else begin
                            txdata_q <= ST_BADOP;
                            cnt_q    <= '0;
                            state_q  <= RESP;
                        end
                    end
                end
                ADDRH: begin
                    if (rx_fire) begin
                        regaddr_q[11:8] <= rxdata[3:0];
                        state_q         <= ADDRL;
                    end
                end
                ADDRL: begin
                    if (rx_fire) begin
                        regaddr_q[7:0] <= rxdata;
                        cnt_q          <= '0;
                        state_q        <= regwr_q ? WDATA : REQ;
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        regwdata_q <= {regwdata_q[23:0], rxdata};
                        if (cnt_q == 3'd3) begin
                            cnt_q   <= '0;
                            state_q <= REQ;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                REQ: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // An ack on the final timer cycle still wins over timeout.
                    if (regack) begin
                        timer_q <= '0;
                        state_q <= RESP;
                        if (regerr) begin
                            txdata_q <= ST_REGERR;
                            cnt_q    <= '0;
                        end else begin
                            txdata_q <= ST_OK;
                            shift_q  <= regrdata;
                            cnt_q    <= regwr_q ? 3'd0 : 3'd4;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        timer_q  <= '0;
                        txdata_q <= ST_TIMEOUT;
                        cnt_q    <= '0;
                        state_q  <= RESP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        if (cnt_q == 3'd0) begin
                            state_q <= IDLE;
                        end else begin
                            txdata_q <= shift_q[31:24];
                            shift_q  <= {shift_q[23:0], 8'h00};
                            cnt_q    <= cnt_q - 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_bridge.sv
// Directed-vector bench for regbus_bridge with hand-computed expected bytes.
module tb_regbus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxdata;
    logic        rxvalid;
    logic        rxready;
    logic [7:0]  txdata;
    logic        txvalid;
    logic        txready;
    logic        regreq;
    logic        regwr;
    logic [11:0] regaddr;
    logic [31:0] regwdata;
    logic        regack;
    logic        regerr;
    logic [31:0] regrdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_count = 0;
    logic [11:0] req_addr = '0;
    logic        req_wr   = 1'b0;
    logic [31:0] req_wdata = '0;

    always #5 clk = ~clk;

    regbus_bridge #(.TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxdata   (rxdata),
        .rxvalid  (rxvalid),
        .rxready  (rxready),
        .txdata   (txdata),
        .txvalid  (txvalid),
        .txready  (txready),
        .regreq   (regreq),
        .regwr    (regwr),
        .regaddr  (regaddr),
        .regwdata (regwdata),
        .regack   (regack),
        .regerr   (regerr),
        .regrdata (regrdata)
    );

    always @(negedge clk) begin
        if (regreq) begin
            req_count = req_count + 1;
            req_addr  = regaddr;
            req_wr    = regwr;
            req_wdata = regwdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rxdata  = b;
        rxvalid = 1'b1;
        while (!rxready && n < 50) begin
            step();
            n++;
        end
        if (!rxready) check("rx_accept_bound", 32'(rxready), 32'd1);
        step();
        rxvalid = 1'b0;
        rxdata  = 8'h00;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!regreq && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(regreq), 32'd1);
    endtask

    task automatic ack_after(input int d, input logic err, input logic [31:0] data);
        repeat (d) step();
        regack   = 1'b1;
        regerr   = err;
        regrdata = data;
        step();
        regack   = 1'b0;
        regerr   = 1'b0;
        regrdata = '0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        txready = 1'b0;
        while (!txvalid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(txvalid), 32'd1);
        check(tag, 32'(txdata), 32'(exp));
        step();
        check({tag, "_hold"}, 32'(txdata), 32'(exp));
        txready = 1'b1;
        step();
        txready = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_txvalid"}, 32'(txvalid), 32'd0);
        check({tag, "_rxready"}, 32'(rxready), 32'd1);
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_rxready"},  32'(rxready),  32'd0);
        check({tag, "_txvalid"},  32'(txvalid),  32'd0);
        check({tag, "_regreq"},   32'(regreq),   32'd0);
        check({tag, "_regwr"},    32'(regwr),    32'd0);
        check({tag, "_regaddr"},  32'(regaddr),  32'd0);
        check({tag, "_regwdata"}, regwdata,      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int steps;
        rst      = 1'b1;
        rxdata   = 8'h00;
        rxvalid  = 1'b0;
        txready  = 1'b0;
        regack   = 1'b0;
        regerr   = 1'b0;
        regrdata = '0;
        #1;
        expect_reset_outputs("por");
        step();
        step();
        rst = 1'b0;
        step();
        expect_idle("post_reset");

        // Read 0x004, ack three cycles after the request.
        base = req_count;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        wait_req("rd1_req");
        ack_after(3, 1'b0, 32'h0000_0400);
        recv_byte("rd1_b0", 8'h00);
        recv_byte("rd1_b1", 8'h00);
        recv_byte("rd1_b2", 8'h00);
        recv_byte("rd1_b3", 8'h04);
        recv_byte("rd1_b4", 8'h00);
        expect_idle("rd1_end");
        check("rd1_reqs", 32'(req_count - base), 32'd1);
        check("rd1_addr", 32'(req_addr), 32'h004);
        check("rd1_wr", 32'(req_wr), 32'd0);

        // Write 0xDEADBEEF to 0x00C; regreq must follow the last data byte directly.
        base = req_count;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h0C);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check("wr1_latency", 32'(regreq), 32'd1);
        wait_req("wr1_req");
        ack_after(1, 1'b0, 32'hFFFF_FFFF);
        recv_byte("wr1_b0", 8'h00);
        expect_idle("wr1_end");
        check("wr1_reqs", 32'(req_count - base), 32'd1);
        check("wr1_addr", 32'(req_addr), 32'h00C);
        check("wr1_wr", 32'(req_wr), 32'd1);
        check("wr1_wdata", req_wdata, 32'hDEAD_BEEF);

        // Read 0x0FF0 (upper nibble of address-high ignored), responder flags error.
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'hF0);
        wait_req("err_req");
        check("err_addr", 32'(regaddr), 32'hFF0);
        ack_after(2, 1'b1, 32'h1234_5678);
        recv_byte("err_b0", 8'h01);
        expect_idle("err_end");

        // No ack: exactly 16 WAIT cycles then timeout status; late ack ignored.
        base = req_count;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h23);
        wait_req("to_req");
        steps = 0;
        do begin
            step();
            steps++;
        end while (!txvalid && steps < 100);
        check("to_wait_cycles", 32'(steps - 1), 32'd16);
        recv_byte("to_b0", 8'h02);
        expect_idle("to_end");
        regack = 1'b1; regerr = 1'b1; regrdata = 32'hCAFE_0000;
        step();
        regack = 1'b0; regerr = 1'b0; regrdata = '0;
        step();
        expect_idle("late_ack");
        check("to_reqs", 32'(req_count - base), 32'd1);

        // Bad opcode gives 0x03 with no bus cycle, then a normal read.
        base = req_count;
        send_byte(8'h7F);
        recv_byte("bad_b0", 8'h03);
        expect_idle("bad_end");
        check("bad_reqs", 32'(req_count - base), 32'd0);
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h40);
        wait_req("rd2_req");
        ack_after(5, 1'b0, 32'hA5C3_1E07);
        recv_byte("rd2_b0", 8'h00);
        recv_byte("rd2_b1", 8'hA5);
        recv_byte("rd2_b2", 8'hC3);
        recv_byte("rd2_b3", 8'h1E);
        recv_byte("rd2_b4", 8'h07);
        expect_idle("rd2_end");
        check("rd2_addr", 32'(req_addr), 32'h340);

        // Reset in the middle of write data.
        base = req_count;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hAA); send_byte(8'hBB);
        rst = 1'b1;
        #1;
        expect_reset_outputs("rst_wdata");
        step();
        rst = 1'b0;
        step();
        expect_idle("rst_wdata_rel");
        check("rst_wdata_reqs", 32'(req_count - base), 32'd0);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h08);
        wait_req("rd3_req");
        check("rd3_addr", 32'(regaddr), 32'h008);
        ack_after(1, 1'b0, 32'h0BAD_F00D);
        recv_byte("rd3_b0", 8'h00);
        recv_byte("rd3_b1", 8'h0B);
        recv_byte("rd3_b2", 8'hAD);
        recv_byte("rd3_b3", 8'hF0);
        recv_byte("rd3_b4", 8'h0D);
        expect_idle("rd3_end");

        // Reset while a response is stalled by txready low.
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        wait_req("rd4_req");
        ack_after(1, 1'b0, 32'h5566_7788);
        check("rd4_txvalid", 32'(txvalid), 32'd1);
        step();
        rst = 1'b1;
        #1;
        expect_reset_outputs("rst_resp");
        step();
        rst = 1'b0;
        step();
        expect_idle("rst_resp_rel");

        base = req_count;
        send_byte(8'h02); send_byte(8'h0A); send_byte(8'hBC);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_req("wr2_req");
        ack_after(2, 1'b0, 32'h0);
        recv_byte("wr2_b0", 8'h00);
        expect_idle("wr2_end");
        check("wr2_reqs", 32'(req_count - base), 32'd1);
        check("wr2_addr", 32'(req_addr), 32'hABC);
        check("wr2_wr", 32'(req_wr), 32'd1);
        check("wr2_wdata", req_wdata, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
